// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM register info in, forwarding and pipeline control out.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [5:0]  ex_opcode;
  logic [4:0]  ex_rw;
  logic        ex_regwrite;
  logic [4:0]  mem_rw;
  logic        mem_regwrite;
  logic        mem_busy;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        stall;
  logic        bubble;
  logic        freeze;
  logic [15:0] stall_count;

  // Pipeline side: supplies stage info, consumes control.
  modport master (
    output id_rs, id_rt, ex_opcode, ex_rw, ex_regwrite, mem_rw, mem_regwrite, mem_busy,
    input  fwd_a, fwd_b, stall, bubble, freeze, stall_count
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, ex_opcode, ex_rw, ex_regwrite, mem_rw, mem_regwrite, mem_busy,
    output fwd_a, fwd_b, stall, bubble, freeze, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall/bubble, memory-wait freeze, operand forwarding
// selects and a saturating count of stalled cycles.
module hazard_ctrl #(
  parameter logic [63:0] LOAD_OPS_MASK = 64'h0000_003B_0000_8000
) (
  input logic         clock,
  input logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

  state_e      state_q, state_d;
  logic        ex_is_load;
  logic        lu_hazard;
  logic        stall_raw, bubble_raw, freeze_raw;
  logic [1:0]  fwd_a_comb, fwd_b_comb;
  logic [1:0]  fwd_a_q, fwd_b_q;
  logic [15:0] stall_count_q;

  // EX beats MEM; register 0 never forwards; a load in EX has no result yet.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic ex_we,
                                         input logic [4:0] ex_dst, input logic ex_load,
                                         input logic mem_we, input logic [4:0] mem_dst);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (ex_we && (ex_dst == src) && !ex_load) begin
        sel = 2'b01;
      end else if (mem_we && (mem_dst == src)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  // Hazard detection and unregistered forward selects.
  always_comb begin
    ex_is_load = LOAD_OPS_MASK[bus.ex_opcode];
    lu_hazard  = bus.ex_regwrite && ex_is_load && (bus.ex_rw != 5'd0) &&
                 ((bus.ex_rw == bus.id_rs) || (bus.ex_rw == bus.id_rt));
    fwd_a_comb = fwd_sel(bus.id_rs, bus.ex_regwrite, bus.ex_rw, ex_is_load,
                         bus.mem_regwrite, bus.mem_rw);
    fwd_b_comb = fwd_sel(bus.id_rt, bus.ex_regwrite, bus.ex_rw, ex_is_load,
                         bus.mem_regwrite, bus.mem_rw);
  end

  // Next state and control outputs; mem_busy outranks a load-use hazard.
  always_comb begin
    state_d    = state_q;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    freeze_raw = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.mem_busy) begin
          stall_raw  = 1'b1;
          freeze_raw = 1'b1;
          state_d    = StMemWait;
        end else if (lu_hazard) begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
          state_d    = StLuStall;
        end
      end
      // Bubble already in ID/EX; no re-detection this cycle.
      StLuStall: begin
        state_d = bus.mem_busy ? StMemWait : StRun;
      end
      StMemWait: begin
        if (bus.mem_busy) begin
          stall_raw  = 1'b1;
          freeze_raw = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Control outputs are forced low while reset is held, without waiting for a clock.
  assign bus.stall       = reset & stall_raw;
  assign bus.bubble      = reset & bubble_raw;
  assign bus.freeze      = reset & freeze_raw;
  assign bus.fwd_a       = freeze_raw ? fwd_a_q : fwd_a_comb;
  assign bus.fwd_b       = freeze_raw ? fwd_b_q : fwd_b_comb;
  assign bus.stall_count = stall_count_q;

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture forward selects on every non-frozen cycle so a freeze replays them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (!freeze_raw) begin
      fwd_a_q <= fwd_a_comb;
      fwd_b_q <= fwd_b_comb;
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_q <= 16'd0;
    end else if ((stall_raw || freeze_raw) && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

endmodule
